ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle multiply/divide unit in the EX stage. It accepts one HI/LO-class operation per issue, computes it iteratively or over a short fixed pipeline, and raises `stall_req` while the result is pending. `stall_req` drives the pipeline controller's `stall_from_ex` input. The unit obeys the controller's `flush_ex` and `stall_ex` outputs, and holds its finished result until the EX stage advances.

## Interface
- `DIV_CYCLES`, 32: number of radix-2 divide iterations; fixed to the operand width.
- `MUL_LATENCY`, 3: cycles from request to result for the multiply class.
- Clock/reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  EX holds a mul/div instruction. Held stable by the pipeline while `stall_req`=1.
- `req_op`  in  `muldiv_op_t` (4)  MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MUL.
- `req_a`, `req_b`  in  32 each  rs/rt operands.
- `hilo_in`  in  64  current {HI,LO} (forwarded); used by MADD/MSUB only.
- `flush`  in  1  `flush_ex` from the controller.
- `advance`  in  1  EX moves to MM this cycle (= ~`stall_ex`).
- `stall_req`  out  1  to `stall_from_ex`.
- `res_valid`  out  1  result available.
- `res_hilo`  out  64  {HI,LO}. For MUL, bits [31:0] are the GPR result.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - `req_valid` & ~`flush`: latch operands and op. Go to MUL (counter = `MUL_LATENCY`-1) or DIV (counter = `DIV_CYCLES`).
  - `stall_req` = `req_valid` combinationally in IDLE, so it is asserted in the request cycle itself.
- MUL:
  - 33×33 signed product; operands are sign- or zero-extended per op.
  - MADD/MSUB add or subtract the product to/from `hilo_in`, sampled at request time.
  - The result is registered in the last stage. Counter reaches 0 → DONE.
- DIV:
  - Absolute values computed at latch.
  - One restoring-division bit per cycle in sub-module `div_iter`.
  - Counter reaches 0 → FIX.
- FIX:
  - Quotient is negated if signed and operand signs differ.
  - Remainder takes the dividend's sign.
  - HI = remainder, LO = quotient. Go to DONE.
- Divide by zero: no trap. Same latency. LO = 0xFFFFFFFF, HI = `req_a`.
- DONE:
  - `res_valid`=1, `stall_req`=0.
  - `advance`=1 → IDLE.
  - `advance`=0 (MM stall) → hold result unchanged.
- `flush`=1 in any state → IDLE next cycle, and the result is discarded.
  - While `flush`=1, `stall_req` is forced 0 in that cycle.
  - `flush` beats a simultaneous new request.
- Non-muldiv `req_op` values are ignored: the unit stays in IDLE with `stall_req`=0.
- A new request is only accepted from IDLE. After DONE→IDLE, the next instruction's request is seen one cycle later.

## Timing
- Reset value of all outputs: 0. Registered `res_hilo` = 0; state IDLE. Reset mid-operation aborts immediately.
- Request seen in IDLE at cycle 0:
  - Multiply class: `stall_req`=1 in cycles 0..2; `res_valid`=1 and `stall_req`=0 from cycle 3.
  - Divide class: `stall_req`=1 in cycles 0..33; `res_valid`=1 from cycle 34 (1 latch + 32 iterate + 1 fix).
- `res_valid` stays 1 until the cycle after `advance`=1 in DONE.
- `res_hilo` is stable throughout DONE.
- All arithmetic is performed on 64-bit, or 33-bit for the divider. MADD/MSUB wrap modulo 2^64.

## Structure
- `cpu_defs.svh` holds:
  - `muldiv_op_t` enum;
  - constants `MULDIV_MUL_LATENCY`=3 and `MULDIV_DIV_LATENCY`=34;
  - `muldiv_state_t`.
- Sub-module `div_iter`: unsigned 32-bit restoring divider.
  - Inputs: `start`, dividend, divisor.
  - Outputs: quotient and remainder, one bit per cycle.
  - Its `clear` input is driven by `flush`.
- The top level handles sign pre/post-processing, the multiply path and the FSM.

## Test plan
- MULT a=0xFFFFFFFF, b=2 → `res_hilo`=0xFFFFFFFF_FFFFFFFE at cycle 3. MULTU with the same operands → 0x00000001_FFFFFFFE. `stall_req` is high for cycles 0–2 only.
- DIV a=−7 (0xFFFFFFF9), b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD at cycle 34. DIVU 100/7 → 0x00000002_0000000E.
- MADD `hilo_in`=1, a=3, b=4 → 0x00000000_0000000D. MSUBU `hilo_in`=0, a=1, b=1 → 0xFFFFFFFF_FFFFFFFF.
- DIVU a=5, b=0 → HI=5, LO=0xFFFFFFFF at cycle 34, with no exception.
- Divide started, `flush` at cycle 10 → state IDLE at cycle 11, `stall_req`=0 at cycle 10, `res_valid` never asserted. A new MULT issued at cycle 11 completes at cycle 14.
- MULT completes while `advance`=0 for 5 cycles → `res_valid` and `res_hilo` held constant. The cycle after `advance`=1, `res_valid`=0. Async `rst_n` low mid-divide → all outputs 0 immediately.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_pkg
// Shared types and constants for the EX-stage multiply/divide unit:
//   muldiv_op_t     - operation selector presented on req_op
//   muldiv_state_t  - FSM state encoding of ex_muldiv
//   MULDIV_*        - request-to-result latencies in cycles
// Helper functions classify an opcode (muldiv or not, divide class, signed).
// ---------------------------------------------------------------------------
package ex_muldiv_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MSUB  = 4'd7,
        MD_MSUBU = 4'd8,
        MD_MUL   = 4'd9
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    localparam int MULDIV_MUL_LATENCY = 3;
    localparam int MULDIV_DIV_LATENCY = 34;

    function automatic logic is_muldiv(input muldiv_op_t op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD,
            MD_MADDU, MD_MSUB, MD_MSUBU, MD_MUL: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input muldiv_op_t op);
        logic r;
        case (op)
            MD_MULT, MD_DIV, MD_MADD, MD_MSUB, MD_MUL: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Unsigned restoring divider, one quotient bit per step.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - abandon the current division (pipeline flush)
//   start       - load dividend/divisor and reset the partial remainder
//   step        - perform one iteration
//   dividend_i  - W-bit unsigned dividend
//   divisor_i   - W-bit unsigned divisor
//   quotient_o  - quotient, valid after W steps
//   remainder_o - remainder, valid after W steps
// The dividend is shifted out of the quotient register's MSB while quotient
// bits are shifted in at the LSB, so one register serves both roles.
// ---------------------------------------------------------------------------
module div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         start,
    input  logic         step,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);

    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] dvs_q;
    logic [W:0]   shifted;
    logic [W:0]   diff;

    // Trial subtraction on W+1 bits: the shifted remainder is always below
    // twice the divisor, so bit W of the difference is a clean sign bit.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[W]) begin
            rem_d = diff[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_d = shifted[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (clear) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// EX-stage multi-cycle multiply/divide unit producing a {HI,LO} result.
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - EX holds a mul/div instruction (held while stall_req=1)
//   req_op      - operation (muldiv_op_t); other values are ignored
//   req_a/req_b - rs/rt operands
//   hilo_in     - forwarded {HI,LO}, accumulator for MADD/MSUB
//   flush       - discard any operation in flight, return to IDLE
//   advance     - EX moves to MM this cycle; releases a finished result
//   stall_req   - hold the pipeline while the result is pending
//   res_valid   - result available (DONE state)
//   res_hilo    - {HI,LO}; for MUL, bits [31:0] are the GPR result
// Multiply class: 3 cycles from request to result. Divide class: 34 cycles
// (latch, 32 iterations, sign fix-up).
// ---------------------------------------------------------------------------
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DIV_CYCLES  = 32,
    parameter int MUL_LATENCY = MULDIV_MUL_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  muldiv_op_t  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [63:0] hilo_in,
    input  logic        flush,
    input  logic        advance,
    output logic        stall_req,
    output logic        res_valid,
    output logic [63:0] res_hilo
);

    muldiv_state_t state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          stall_c;
    logic          accept;

    // Latched operation context
    muldiv_op_t          op_q;
    logic [31:0]         a_q;
    logic signed [32:0]  mul_a_q;
    logic signed [32:0]  mul_b_q;
    logic [63:0]         acc_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                bzero_q;

    // Multiply pipeline and result
    logic signed [65:0]  prod_full;
    logic [63:0]         prod_q;
    logic [63:0]         mul_final;
    logic [63:0]         div_final;
    logic [63:0]         res_q;

    // Divider interface
    logic                req_sgn;
    logic [31:0]         dvd_abs;
    logic [31:0]         dvs_abs;
    logic [31:0]         quo;
    logic [31:0]         rem;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    assign accept  = (state_q == ST_IDLE) && req_valid && !flush && is_muldiv(req_op);
    assign req_sgn = is_signed_op(req_op);
    assign dvd_abs = cond_neg(req_a, req_sgn && req_a[31]);
    assign dvs_abs = cond_neg(req_b, req_sgn && req_b[31]);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Stall in the request cycle itself so EX holds the operands.
                stall_c = req_valid && is_muldiv(req_op);
                if (accept) begin
                    if (is_div(req_op)) begin
                        state_d = ST_DIV;
                        cnt_d   = 6'(DIV_CYCLES);
                    end else begin
                        state_d = ST_MUL;
                        cnt_d   = 6'(MUL_LATENCY - 1);
                    end
                end
            end
            ST_MUL: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 6'd1;
                if (cnt_q <= 6'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 6'd1;
                if (cnt_q <= 6'd1) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                stall_c = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (advance) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flush wins over everything, including a request in the same cycle.
        if (flush) begin
            state_d = ST_IDLE;
            stall_c = 1'b0;
        end
    end

    // ---------------- Operand latch (stage p0) ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= req_op;
            a_q       <= req_a;
            mul_a_q   <= $signed({req_sgn & req_a[31], req_a});
            mul_b_q   <= $signed({req_sgn & req_b[31], req_b});
            acc_q     <= hilo_in;
            neg_quo_q <= req_sgn && (req_a[31] ^ req_b[31]);
            neg_rem_q <= req_sgn && req_a[31];
            bzero_q   <= (req_b == 32'd0);
        end
    end

    // ---------------- Product (stage p1) ----------------
    assign prod_full = mul_a_q * mul_b_q;

    always_ff @(posedge clk) begin
        if (state_q == ST_MUL) begin
            prod_q <= prod_full[63:0];
        end
    end

    always_comb begin
        case (op_q)
            MD_MADD, MD_MADDU: mul_final = acc_q + prod_q;
            MD_MSUB, MD_MSUBU: mul_final = acc_q - prod_q;
            default:           mul_final = prod_q;
        endcase
    end

    // ---------------- Divider ----------------
    div_iter #(
        .W(32)
    ) u_div_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .start      (accept && is_div(req_op)),
        .step       (state_q == ST_DIV),
        .dividend_i (dvd_abs),
        .divisor_i  (dvs_abs),
        .quotient_o (quo),
        .remainder_o(rem)
    );

    // Divide by zero bypasses the sign fix so HI returns the raw dividend.
    assign div_final = bzero_q ? {a_q, 32'hFFFF_FFFF}
                               : {cond_neg(rem, neg_rem_q), cond_neg(quo, neg_quo_q)};

    // ---------------- Result register (stage p2) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (!flush) begin
            if ((state_q == ST_MUL) && (cnt_q <= 6'd1)) begin
                res_q <= mul_final;
            end else if (state_q == ST_FIX) begin
                res_q <= div_final;
            end
        end
    end

    // Gated by rst_n so the combinational IDLE stall also reads 0 in reset.
    assign stall_req = stall_c && rst_n;
    assign res_valid = (state_q == ST_DONE);
    assign res_hilo  = res_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    muldiv_op_t  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [63:0] hilo_in;
    logic        flush;
    logic        advance;
    logic        stall_req;
    logic        res_valid;
    logic [63:0] res_hilo;

    ex_muldiv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .hilo_in  (hilo_in),
        .flush    (flush),
        .advance  (advance),
        .stall_req(stall_req),
        .res_valid(res_valid),
        .res_hilo (res_hilo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hilo;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic        prev_v = 1'b0;
    logic [63:0] held   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural definition.
    function automatic logic [63:0] model(input muldiv_op_t op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        longint sa, sb, ua, ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            MD_MULT, MD_MUL: r = 64'(sa * sb);
            MD_MULTU:        r = 64'(ua * ub);
            MD_MADD:         r = h + 64'(sa * sb);
            MD_MADDU:        r = h + 64'(ua * ub);
            MD_MSUB:         r = h - 64'(sa * sb);
            MD_MSUBU:        r = h - 64'(ua * ub);
            MD_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {32'(sa % sb), 32'(sa / sb)};
            end
            MD_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Monitor: pops one expectation per result and checks it stays put.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (!prev_v) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h expected no result (cycle %0d)", res_hilo, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("res_hilo", res_hilo, e.hilo);
                    check("latency", 64'(cyc - e.issue), 64'(e.lat));
                end
                held = res_hilo;
            end else begin
                check("hold_hilo", res_hilo, held);
            end
        end
        prev_v = rst_n && res_valid;
    end

    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h, input int hold);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        flush     = 1'b0;
        advance   = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        hilo_in   = h;
        e.hilo  = model(op, a, b, h);
        e.issue = cyc;
        e.lat   = is_div(op) ? MULDIV_DIV_LATENCY : MULDIV_MUL_LATENCY;
        sb_q.push_back(e);
        #1 check("stall_req_issue", 64'(stall_req), 64'd1);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (res_valid) break;
            if (n > 60) break;
            check("stall_req_busy", 64'(stall_req), 64'd1);
        end
        if (!res_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: got no res_valid expected res_valid within 60 cycles");
            req_valid = 1'b0;
            flush     = 1'b1;
            @(posedge clk); #1;
            flush     = 1'b0;
            return;
        end
        check("stall_req_done", 64'(stall_req), 64'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("res_valid_held", 64'(res_valid), 64'd1);
        end
        advance = 1'b1;
        @(posedge clk); #1;
        advance   = 1'b0;
        req_valid = 1'b0;
        check("res_valid_drop", 64'(res_valid), 64'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20));
            4:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    muldiv_op_t ops [9] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD,
                            MD_MADDU, MD_MSUB, MD_MSUBU, MD_MUL};

    initial begin
        int c0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = MD_NONE;
        req_a     = '0;
        req_b     = '0;
        hilo_in   = '0;
        flush     = 1'b0;
        advance   = 1'b0;
        #1;
        check("rst_stall_req", 64'(stall_req), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_hilo", res_hilo, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, 64'd0, 0);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 64'd0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 64'd0, 0);
        run_op(MD_DIVU,  32'd100, 32'd7, 64'd0, 1);
        run_op(MD_MADD,  32'd3, 32'd4, 64'd1, 0);
        run_op(MD_MSUBU, 32'd1, 32'd1, 64'd0, 0);
        run_op(MD_DIVU,  32'd5, 32'd0, 64'd0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF0, 32'd0, 64'd0, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 0);
        run_op(MD_MULT,  32'h1234_5678, 32'h9ABC_DEF0, 64'd0, 5);

        // Opcodes outside the muldiv set are ignored.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = muldiv_op_t'(4'hF);
        #1 check("nonop_stall", 64'(stall_req), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("nonop_res_valid", 64'(res_valid), 64'd0);
            check("nonop_stall_hold", 64'(stall_req), 64'd0);
        end
        req_valid = 1'b0;
        req_op    = MD_NONE;

        // Divide flushed at cycle 10, then a MULT issued the next cycle.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = MD_DIVU;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        c0        = cyc;
        repeat (10) @(posedge clk);
        #1;
        check("flush_cycle", 64'(cyc - c0), 64'd10);
        flush = 1'b1;
        #1 check("flush_stall", 64'(stall_req), 64'd0);
        run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, 64'd0, 0);

        // Flush beats a simultaneous request.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = MD_MULT;
        flush     = 1'b1;
        #1 check("flush_req_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("flush_req_novalid", 64'(res_valid), 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            run_op(ops[$urandom_range(0, 8)], rnd_opnd(), rnd_opnd(),
                   {$urandom, $urandom}, $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = MD_DIV;
        req_a     = 32'd12345;
        req_b     = 32'd11;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stall_req", 64'(stall_req), 64'd0);
        check("arst_res_valid", 64'(res_valid), 64'd0);
        check("arst_res_hilo", res_hilo, 64'd0);
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            check("arst_no_result", 64'(res_valid), 64'd0);
        end

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
